// File: rtl/vslc_timer_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : vslc_timer_bank_if
// Purpose  : Configuration bus of the VSLC timer bank. One single-cycle
//            write strobe selects a channel and a register field and carries
//            the write data.
// Signals  : cfg_we    - write strobe, one clk per write
//            cfg_ch    - target channel (values >= N_CH are ignored)
//            cfg_field - 0 period_a, 1 period_b, 2 ctrl {mode,div}, 3 reserved
//            cfg_data  - write data
// Modports : master drives the bus, slave (the timer bank) receives it.
// Revision : 1.0 - initial release
// ============================================================================
interface vslc_timer_bank_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 10
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic             cfg_we;
    logic [CH_W-1:0]  cfg_ch;
    logic [1:0]       cfg_field;
    logic [CNT_W-1:0] cfg_data;

    modport master (
        output cfg_we,
        output cfg_ch,
        output cfg_field,
        output cfg_data
    );

    modport slave (
        input  cfg_we,
        input  cfg_ch,
        input  cfg_field,
        input  cfg_data
    );
endinterface
`default_nettype wire

// File: rtl/vslc_timer_bank.sv
`default_nettype none
// ============================================================================
// Module   : vslc_timer_bank
// Purpose  : Bank of N_CH independent PLC timers. Each channel has its own
//            power-of-two prescaler, two period registers and one of four
//            modes: CYCLE, ONESHOT, TON (on-delay) and TOF (off-delay).
// Ports    : clk          - system clock, rising edge
//            rst_n        - asynchronous active-low reset
//            cfg_if       - configuration bus (slave modport)
//            run_i        - per-channel enable / trigger level
//            tmr_out_o    - registered timer outputs
//            tmr_active_o - channel is currently timing an interval
//            tmr_done_o   - one-clk pulse at the end of an interval
// Revision : 1.0 - initial release
// ============================================================================
module vslc_timer_bank #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 10,
    parameter int DIV_W = 4
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    vslc_timer_bank_if.slave     cfg_if,
    input  wire logic [N_CH-1:0] run_i,
    output logic      [N_CH-1:0] tmr_out_o,
    output logic      [N_CH-1:0] tmr_active_o,
    output logic      [N_CH-1:0] tmr_done_o
);
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int PRE_W = 2 ** DIV_W;

    localparam logic [1:0] MODE_CYCLE   = 2'd0;
    localparam logic [1:0] MODE_ONESHOT = 2'd1;
    localparam logic [1:0] MODE_TON     = 2'd2;

    localparam logic [1:0] FIELD_PA   = 2'd0;
    localparam logic [1:0] FIELD_PB   = 2'd1;
    localparam logic [1:0] FIELD_CTRL = 2'd2;

    // IDLE: not counting. CNT_A / CNT_B: timing period_a / period_b.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CNT_A = 2'd1,
        ST_CNT_B = 2'd2
    } state_t;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [CNT_W-1:0] period_a_q, period_a_d;
        logic [CNT_W-1:0] period_b_q, period_b_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [PRE_W-1:0] pre_q, pre_d;
        logic [1:0]       mode_q, mode_d;
        logic [DIV_W-1:0] div_q, div_d;
        state_t           state_q, state_d;
        logic             out_q, out_d;
        logic             done_q, done_d;
        logic             run_prev_q;

        logic             w_sel, w_wr_a, w_wr_b, w_wr_ctrl;
        logic             w_run, w_rise, w_fall;
        logic             w_tick, w_fin, w_count;
        logic [PRE_W-1:0] w_pre_mask;
        logic [CNT_W-1:0] w_raw_a, w_raw_b, w_raw_per, w_per, w_cnt_inc;

        assign w_sel     = cfg_if.cfg_we && (cfg_if.cfg_ch == CH_W'(g));
        assign w_wr_a    = w_sel && (cfg_if.cfg_field == FIELD_PA);
        assign w_wr_b    = w_sel && (cfg_if.cfg_field == FIELD_PB);
        assign w_wr_ctrl = w_sel && (cfg_if.cfg_field == FIELD_CTRL);

        assign w_run  = run_i[g];
        assign w_rise = w_run && !run_prev_q;
        assign w_fall = !w_run && run_prev_q;

        // A period write landing on the same edge as a comparison takes
        // effect in that comparison; a zero period behaves as one tick.
        assign w_raw_a   = w_wr_a ? cfg_if.cfg_data : period_a_q;
        assign w_raw_b   = w_wr_b ? cfg_if.cfg_data : period_b_q;
        assign w_raw_per = (state_q == ST_CNT_B) ? w_raw_b : w_raw_a;
        assign w_per     = (w_raw_per == '0) ? CNT_W'(1) : w_raw_per;

        // Tick when the low div bits of the prescaler are all ones.
        assign w_pre_mask = (PRE_W'(1) << div_q) - PRE_W'(1);
        assign w_tick     = ((pre_q & w_pre_mask) == w_pre_mask);

        // Saturating increment: a counter already at or beyond a freshly
        // shrunk period finishes on the next tick instead of wrapping.
        assign w_cnt_inc = (cnt_q >= w_per) ? w_per : (cnt_q + CNT_W'(1));
        assign w_fin     = w_tick && (w_cnt_inc >= w_per);

        always_comb begin
            period_a_d = w_wr_a ? cfg_if.cfg_data : period_a_q;
            period_b_d = w_wr_b ? cfg_if.cfg_data : period_b_q;
            mode_d     = mode_q;
            div_d      = div_q;
            state_d    = state_q;
            out_d      = out_q;
            done_d     = 1'b0;
            cnt_d      = cnt_q;
            pre_d      = pre_q;
            w_count    = 1'b0;

            if (w_wr_ctrl) begin
                mode_d  = cfg_if.cfg_data[DIV_W+1:DIV_W];
                div_d   = cfg_if.cfg_data[DIV_W-1:0];
                state_d = ST_IDLE;
                out_d   = 1'b0;
                cnt_d   = '0;
                pre_d   = '0;
            end else begin
                case (mode_q)
                    MODE_CYCLE: begin
                        if (!w_run) begin
                            state_d = ST_IDLE;
                            out_d   = 1'b0;
                            cnt_d   = '0;
                            pre_d   = '0;
                        end else if (state_q == ST_IDLE) begin
                            state_d = ST_CNT_A;
                            out_d   = 1'b0;
                            cnt_d   = '0;
                            pre_d   = '0;
                        end else begin
                            w_count = 1'b1;
                            if (w_fin) begin
                                if (state_q == ST_CNT_A) begin
                                    state_d = ST_CNT_B;
                                    out_d   = 1'b1;
                                end else begin
                                    state_d = ST_CNT_A;
                                    out_d   = 1'b0;
                                    done_d  = 1'b1;
                                end
                            end
                        end
                    end
                    MODE_ONESHOT: begin
                        // Non-retriggerable: edges are only looked at when idle.
                        if (state_q == ST_IDLE) begin
                            if (w_rise) begin
                                state_d = ST_CNT_A;
                                out_d   = 1'b1;
                                cnt_d   = '0;
                                pre_d   = '0;
                            end
                        end else begin
                            w_count = 1'b1;
                            if (w_fin) begin
                                state_d = ST_IDLE;
                                out_d   = 1'b0;
                                done_d  = 1'b1;
                            end
                        end
                    end
                    MODE_TON: begin
                        // out_q high while idle means the delay already
                        // elapsed and the output is being held.
                        if (!w_run) begin
                            state_d = ST_IDLE;
                            out_d   = 1'b0;
                            cnt_d   = '0;
                            pre_d   = '0;
                        end else if (state_q == ST_IDLE) begin
                            if (!out_q) begin
                                state_d = ST_CNT_A;
                                cnt_d   = '0;
                                pre_d   = '0;
                            end
                        end else begin
                            w_count = 1'b1;
                            if (w_fin) begin
                                state_d = ST_IDLE;
                                out_d   = 1'b1;
                                done_d  = 1'b1;
                            end
                        end
                    end
                    default: begin
                        // TOF: output follows run high, drops after the
                        // off-delay; run returning high cancels the delay.
                        if (w_run) begin
                            state_d = ST_IDLE;
                            out_d   = 1'b1;
                            cnt_d   = '0;
                            pre_d   = '0;
                        end else if (state_q == ST_IDLE) begin
                            if (w_fall) begin
                                state_d = ST_CNT_A;
                                cnt_d   = '0;
                                pre_d   = '0;
                            end
                        end else begin
                            w_count = 1'b1;
                            if (w_fin) begin
                                state_d = ST_IDLE;
                                out_d   = 1'b0;
                                done_d  = 1'b1;
                            end
                        end
                    end
                endcase

                if (w_count) begin
                    if (w_tick) begin
                        pre_d = '0;
                        cnt_d = w_fin ? '0 : w_cnt_inc;
                    end else begin
                        pre_d = pre_q + PRE_W'(1);
                    end
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                period_a_q <= CNT_W'(1);
                period_b_q <= CNT_W'(2);
                mode_q     <= MODE_CYCLE;
                div_q      <= '0;
                cnt_q      <= '0;
                pre_q      <= '0;
                state_q    <= ST_IDLE;
                out_q      <= 1'b0;
                done_q     <= 1'b0;
                run_prev_q <= 1'b0;
            end else begin
                period_a_q <= period_a_d;
                period_b_q <= period_b_d;
                mode_q     <= mode_d;
                div_q      <= div_d;
                cnt_q      <= cnt_d;
                pre_q      <= pre_d;
                state_q    <= state_d;
                out_q      <= out_d;
                done_q     <= done_d;
                run_prev_q <= w_run;
            end
        end

        assign tmr_out_o[g]    = out_q;
        assign tmr_active_o[g] = (state_q != ST_IDLE);
        assign tmr_done_o[g]   = done_q;
    end
endmodule
`default_nettype wire

// File: tb/tb_vslc_timer_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_vslc_timer_bank
// Purpose  : Self-checking bench for vslc_timer_bank. A clock-level model
//            (elapsed clocks against P*2**div) is compared with the DUT on
//            every falling edge; directed sequences also check hand-computed
//            output patterns. Three channels are used so that an out-of-range
//            channel number exists on the 2-bit channel field.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vslc_timer_bank;
    localparam int N_CH  = 3;
    localparam int CNT_W = 10;
    localparam int DIV_W = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N_CH-1:0] run;
    logic [N_CH-1:0] tmr_out, tmr_active, tmr_done;

    vslc_timer_bank_if #(.N_CH(N_CH), .CNT_W(CNT_W)) cfg_if ();

    vslc_timer_bank #(.N_CH(N_CH), .CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_if       (cfg_if.slave),
        .run_i        (run),
        .tmr_out_o    (tmr_out),
        .tmr_active_o (tmr_active),
        .tmr_done_o   (tmr_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: each channel remembers how many clocks have elapsed since the
    // interval started and ends it at max(P,1) * 2**div clocks.
    // ------------------------------------------------------------------
    logic [1:0] m_mode [N_CH];
    int         m_div  [N_CH];
    int         m_pa   [N_CH];
    int         m_pb   [N_CH];
    int         m_el   [N_CH];
    bit         m_out  [N_CH];
    bit         m_busy [N_CH];
    bit         m_done [N_CH];
    bit         m_phb  [N_CH];
    bit         m_prev [N_CH];
    bit         m_r, m_sel;
    int         m_len;

    function automatic int span(input int p, input int d);
        return ((p == 0) ? 1 : p) << d;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                m_mode[ch] = 2'd0; m_div[ch] = 0; m_pa[ch] = 1; m_pb[ch] = 2;
                m_el[ch] = 0; m_out[ch] = 0; m_busy[ch] = 0; m_done[ch] = 0;
                m_phb[ch] = 0; m_prev[ch] = 0;
            end
        end else begin
            for (int ch = 0; ch < N_CH; ch++) begin
                m_r   = run[ch];
                m_sel = cfg_if.cfg_we && (int'(cfg_if.cfg_ch) == ch);
                m_done[ch] = 0;
                if (m_sel && cfg_if.cfg_field == 2'd2) begin
                    m_mode[ch] = cfg_if.cfg_data[DIV_W+1:DIV_W];
                    m_div[ch]  = int'(cfg_if.cfg_data[DIV_W-1:0]);
                    m_busy[ch] = 0; m_out[ch] = 0; m_phb[ch] = 0; m_el[ch] = 0;
                end else begin
                    m_len = span(m_phb[ch] ? m_pb[ch] : m_pa[ch], m_div[ch]);
                    case (m_mode[ch])
                        2'd0: begin
                            if (!m_r) begin
                                m_busy[ch] = 0; m_out[ch] = 0; m_phb[ch] = 0;
                            end else if (!m_busy[ch]) begin
                                m_busy[ch] = 1; m_out[ch] = 0; m_phb[ch] = 0; m_el[ch] = 0;
                            end else begin
                                m_el[ch]++;
                                if (m_el[ch] == m_len) begin
                                    m_el[ch] = 0;
                                    if (!m_phb[ch]) begin
                                        m_phb[ch] = 1; m_out[ch] = 1;
                                    end else begin
                                        m_phb[ch] = 0; m_out[ch] = 0; m_done[ch] = 1;
                                    end
                                end
                            end
                        end
                        2'd1: begin
                            if (!m_busy[ch]) begin
                                if (m_r && !m_prev[ch]) begin
                                    m_busy[ch] = 1; m_out[ch] = 1; m_el[ch] = 0;
                                end
                            end else begin
                                m_el[ch]++;
                                if (m_el[ch] == m_len) begin
                                    m_busy[ch] = 0; m_out[ch] = 0; m_done[ch] = 1;
                                end
                            end
                        end
                        2'd2: begin
                            if (!m_r) begin
                                m_busy[ch] = 0; m_out[ch] = 0;
                            end else if (!m_busy[ch] && !m_out[ch]) begin
                                m_busy[ch] = 1; m_el[ch] = 0;
                            end else if (m_busy[ch]) begin
                                m_el[ch]++;
                                if (m_el[ch] == m_len) begin
                                    m_busy[ch] = 0; m_out[ch] = 1; m_done[ch] = 1;
                                end
                            end
                        end
                        default: begin
                            if (m_r) begin
                                m_busy[ch] = 0; m_out[ch] = 1;
                            end else if (m_prev[ch] && !m_busy[ch]) begin
                                m_busy[ch] = 1; m_el[ch] = 0;
                            end else if (m_busy[ch]) begin
                                m_el[ch]++;
                                if (m_el[ch] == m_len) begin
                                    m_busy[ch] = 0; m_out[ch] = 0; m_done[ch] = 1;
                                end
                            end
                        end
                    endcase
                end
                if (m_sel && cfg_if.cfg_field == 2'd0) m_pa[ch] = int'(cfg_if.cfg_data);
                if (m_sel && cfg_if.cfg_field == 2'd1) m_pb[ch] = int'(cfg_if.cfg_data);
                m_prev[ch] = m_r;
            end
        end
    end

    // Per-cycle comparison against the model.
    logic [N_CH-1:0] e_out, e_act, e_done;
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                e_out[ch]  = m_out[ch];
                e_act[ch]  = m_busy[ch];
                e_done[ch] = m_done[ch];
            end
            chk("model_out",    32'(tmr_out),    32'(e_out));
            chk("model_active", 32'(tmr_active), 32'(e_act));
            chk("model_done",   32'(tmr_done),   32'(e_done));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (called at a falling edge)
    // ------------------------------------------------------------------
    task automatic cfg_write(input int ch, input int field, input int data);
        cfg_if.cfg_we    = 1'b1;
        cfg_if.cfg_ch    = ch[1:0];
        cfg_if.cfg_field = field[1:0];
        cfg_if.cfg_data  = data[CNT_W-1:0];
        @(negedge clk);
        cfg_if.cfg_we    = 1'b0;
    endtask

    // Bit i of pat drives run[ch] into edge i; bit i of the results is the
    // output sampled after that edge.
    task automatic run_seq(input int ch, input logic [31:0] pat, input int n,
                           output logic [31:0] o, output logic [31:0] d,
                           output logic [31:0] a);
        o = '0; d = '0; a = '0;
        for (int i = 0; i < n; i++) begin
            run[ch] = pat[i];
            @(negedge clk);
            o[i] = tmr_out[ch];
            d[i] = tmr_done[ch];
            a[i] = tmr_active[ch];
        end
    endtask

    logic [31:0] po, pd, pa;

    initial begin
        rst_n            = 1'b0;
        run              = '0;
        cfg_if.cfg_we    = 1'b0;
        cfg_if.cfg_ch    = '0;
        cfg_if.cfg_field = '0;
        cfg_if.cfg_data  = '0;

        repeat (2) @(negedge clk);
        chk("rst_out",    32'(tmr_out),    32'h0);
        chk("rst_active", 32'(tmr_active), 32'h0);
        chk("rst_done",   32'(tmr_done),   32'h0);
        #1 rst_n = 1'b1;

        // T1: all channels run CYCLE with reset defaults, async reset mid-run
        @(negedge clk);
        run = '1;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        chk("t1_pre_out",    32'(tmr_out),    32'h7);
        chk("t1_pre_active", 32'(tmr_active), 32'h7);
        #1 rst_n = 1'b0;
        #1;
        chk("t1_async_out",    32'(tmr_out),    32'h0);
        chk("t1_async_active", 32'(tmr_active), 32'h0);
        chk("t1_async_done",   32'(tmr_done),   32'h0);
        run = '0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        run_seq(0, 32'hFFFF_FFFF, 9, po, pd, pa);
        chk("t1_default_out",  po, 32'h1B6);
        chk("t1_default_done", pd, 32'h048);
        run[0] = 1'b0;
        repeat (2) @(negedge clk);

        // T2: CYCLE a=3 b=2 div=0
        cfg_write(0, 0, 3);
        cfg_write(0, 1, 2);
        run_seq(0, 32'hFFFF_FFFF, 10, po, pd, pa);
        chk("t2_out",    po, 32'h318);
        chk("t2_done",   pd, 32'h020);
        chk("t2_active", pa, 32'h3FF);

        // T3: ONESHOT div=2 a=4, second pulse while active is ignored
        cfg_write(1, 2, 'h12);
        cfg_write(1, 0, 4);
        run_seq(1, 32'h21, 20, po, pd, pa);
        chk("t3_out",    po, 32'h0FFFF);
        chk("t3_done",   pd, 32'h10000);
        chk("t3_active", pa, 32'h0FFFF);

        // T4: TON a=5, interrupted attempt then a complete one
        cfg_write(2, 2, 'h20);
        cfg_write(2, 0, 5);
        run_seq(2, 32'h3F7, 12, po, pd, pa);
        chk("t4_out",  po, 32'h200);
        chk("t4_done", pd, 32'h200);

        // T5: TOF a=4, delay cancelled by re-rise then completed
        cfg_write(2, 2, 'h30);
        cfg_write(2, 0, 4);
        run_seq(2, 32'h4F, 14, po, pd, pa);
        chk("t5_out",    po, 32'h7FF);
        chk("t5_done",   pd, 32'h800);
        chk("t5_active", pa, 32'h7B0);

        // Zero periods behave as one clock each
        cfg_write(2, 2, 'h00);
        cfg_write(2, 0, 0);
        cfg_write(2, 1, 0);
        run_seq(2, 32'hFFFF_FFFF, 6, po, pd, pa);
        chk("p0_out",  po, 32'h2A);
        chk("p0_done", pd, 32'h14);
        run[2] = 1'b0;
        @(negedge clk);

        // T6: ctrl write to ch1 while ch0 and ch1 run; invalid writes
        cfg_write(1, 2, 'h00);
        run[1] = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_ch1_running", 32'(tmr_active[1]), 32'h1);
        cfg_write(1, 2, 'h10);
        chk("t6_ch1_idle",   32'(tmr_active[1]), 32'h0);
        chk("t6_ch1_out",    32'(tmr_out[1]),    32'h0);
        chk("t6_ch0_active", 32'(tmr_active[0]), 32'h1);
        repeat (3) @(negedge clk);
        chk("t6_ch1_still_idle", 32'(tmr_active[1]), 32'h0);
        cfg_write(3, 2, 'h10);
        cfg_write(0, 3, 'h3FF);
        repeat (4) @(negedge clk);
        chk("t6_ch0_unaffected", 32'(tmr_active[0]), 32'h1);
        run = '0;
        repeat (3) @(negedge clk);
        chk("end_idle", 32'(tmr_active), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected end of test");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
